// File: rtl/bp_cacc_coh_flit_tx.sv
// bp_cacc_coh_flit_tx
//   Serializes one wide coherence message per handshake into a wormhole
//   packet (1 header flit + len body flits) on a ready/valid mesh link.
//   Single-entry message buffer; back-to-back packets leave no bubble.
//
// Ports
//   clk_i             clock, all state on rising edge
//   async_reset_n_i   asynchronous active-low reset
//   msg_i             message to send, bit 0 first
//   dst_cord_i        destination cord
//   len_i             body flits after the header (clamped to max_len_p)
//   v_i               message valid
//   ready_and_o       message accepted when v_i & ready_and_o
//   link_data_o       outgoing flit
//   link_v_o          flit valid
//   link_ready_and_i  flit accepted when link_v_o & link_ready_and_i
//   busy_o            packet in flight
module bp_cacc_coh_flit_tx #(
  parameter int unsigned flit_width_p = 64,
  parameter int unsigned cord_width_p = 8,
  parameter int unsigned len_width_p  = 4,
  parameter int unsigned max_len_p    = 8,
  parameter int unsigned msg_width_p  = (flit_width_p - cord_width_p - len_width_p)
                                        + max_len_p * flit_width_p
) (
  input  logic                    clk_i,
  input  logic                    async_reset_n_i,
  input  logic [msg_width_p-1:0]  msg_i,
  input  logic [cord_width_p-1:0] dst_cord_i,
  input  logic [len_width_p-1:0]  len_i,
  input  logic                    v_i,
  output logic                    ready_and_o,
  output logic [flit_width_p-1:0] link_data_o,
  output logic                    link_v_o,
  input  logic                    link_ready_and_i,
  output logic                    busy_o
);

  localparam int unsigned hdr_pay_w = flit_width_p - cord_width_p - len_width_p;
  localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_len_p);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                  state_r, state_n;
  logic [len_width_p-1:0]  flit_cnt_r, flit_cnt_n;
  logic [len_width_p-1:0]  len_r;
  logic [len_width_p-1:0]  len_clamped;
  logic [msg_width_p-1:0]  msg_r;
  logic [cord_width_p-1:0] cord_r;
  logic                    capture;
  logic                    ready_raw;
  logic                    last_flit;
  logic                    flit_hs;

  assign len_clamped = (len_i > max_len_lp) ? max_len_lp : len_i;
  assign last_flit   = (flit_cnt_r == len_r);

  // Link outputs come from registered state only.
  assign link_v_o = (state_r == SEND);
  assign busy_o   = (state_r == SEND);
  assign flit_hs  = link_v_o & link_ready_and_i;

  // ready is forced low while reset is held, independent of the state register.
  assign ready_and_o = ready_raw & async_reset_n_i;

  always_comb begin
    state_n    = state_r;
    flit_cnt_n = flit_cnt_r;
    ready_raw  = 1'b0;
    capture    = 1'b0;
    case (state_r)
      IDLE: begin
        ready_raw = 1'b1;
        if (v_i) begin
          capture    = 1'b1;
          flit_cnt_n = '0;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (flit_hs) begin
          if (last_flit) begin
            // Buffer frees on the last flit handshake, so a waiting message
            // is taken in the same cycle and the next header follows directly.
            ready_raw  = 1'b1;
            flit_cnt_n = '0;
            if (v_i) capture = 1'b1;
            else     state_n = IDLE;
          end else begin
            flit_cnt_n = flit_cnt_r + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    link_data_o = {msg_r[hdr_pay_w-1:0], len_r, cord_r};
    for (int unsigned k = 1; k <= max_len_p; k++) begin
      if (flit_cnt_r == len_width_p'(k))
        link_data_o = msg_r[hdr_pay_w + (k-1)*flit_width_p +: flit_width_p];
    end
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_r    <= IDLE;
      flit_cnt_r <= '0;
      msg_r      <= '0;
      cord_r     <= '0;
      len_r      <= '0;
    end else begin
      state_r    <= state_n;
      flit_cnt_r <= flit_cnt_n;
      if (capture) begin
        msg_r  <= msg_i;
        cord_r <= dst_cord_i;
        len_r  <= len_clamped;
      end
    end
  end

  len_in_range: assert property (@(posedge clk_i) disable iff (!async_reset_n_i)
                                 (capture |-> (len_i <= max_len_lp)))
    else $warning("len_i above max_len_p at capture; clamped");

endmodule
